// File: rtl/monitor_bus_arbiter_if.sv
// Bundle of CPU port, host port and monitor window signals for the arbiter.
// Latency: none (wires only).
// Backpressure: CPU is strobe/ack, host is level-request/ack, window is fixed-timing.
interface monitor_bus_arbiter_if;
  // CPU (6502 bus logic) port
  logic       cpu_req;
  logic [7:0] cpu_addr;
  logic       cpu_we;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       cpu_overrun;
  // host debug link port
  logic       host_req;
  logic [7:0] host_addr;
  logic       host_we;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       host_err;
  // monitor control and window
  logic       stopped;
  logic [7:0] A;
  logic       write;
  logic [7:0] Din;
  logic [7:0] Dout;

  // arbiter side
  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_overrun,
    input  host_req, host_addr, host_we, host_wdata,
    output host_ack, host_rdata, host_err,
    input  stopped, Dout,
    output A, write, Din
  );

  // requesters and window side
  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_overrun,
    output host_req, host_addr, host_we, host_wdata,
    input  host_ack, host_rdata, host_err,
    output stopped, Dout,
    input  A, write, Din
  );
endinterface

// File: rtl/monitor_bus_arbiter.sv
// Shares the monitor register/ROM window between the CPU port and a host debug port.
// Latency: request sampled in IDLE -> ack 3 cycles later; one access per 3 cycles.
// Backpressure: CPU gets a one-deep pending slot (overflow sets sticky overrun); host holds req until ack.
module monitor_bus_arbiter #(
  parameter logic [7:0] IDLE_ADDR       = 8'h00,
  parameter logic [7:0] MAX_WAIT        = 8'd16,
  parameter bit         ALLOW_RUN_WRITE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  monitor_bus_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADDR   = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_REFUSE = 2'd3;

  logic [1:0] state;
  logic       owner_host;
  logic [7:0] a_q;
  logic       write_q;
  logic [7:0] din_q;

  logic       pend_vld;
  logic [7:0] pend_addr;
  logic       pend_we;
  logic [7:0] pend_wdata;

  logic [7:0] wait_cnt;

  logic       cpu_ack_q;
  logic [7:0] cpu_rdata_q;
  logic       overrun_q;
  logic       host_ack_q;
  logic [7:0] host_rdata_q;
  logic       host_err_q;

  logic       idle;
  logic       host_win;
  logic       cpu_grant;
  logic       host_grant;
  logic       host_refuse;
  logic       cpu_to_slot;
  logic       slot_free;
  logic [7:0] sel_addr;
  logic       sel_we;
  logic [7:0] sel_wdata;

  // Arbitration: CPU first unless the host has waited MAX_WAIT cycles; pending CPU beats a new strobe.
  always_comb begin
    idle        = (state == S_IDLE);
    host_win    = bus.host_req && (wait_cnt >= MAX_WAIT);
    cpu_grant   = idle && !host_win && (bus.cpu_req || pend_vld);
    host_grant  = idle && bus.host_req && !cpu_grant;
    host_refuse = bus.host_we && !bus.stopped && !ALLOW_RUN_WRITE;
    // A new strobe needs the slot unless it is being served directly this cycle.
    cpu_to_slot = bus.cpu_req && !(cpu_grant && !pend_vld);
    // The slot frees up in the same cycle its contents are granted.
    slot_free   = !pend_vld || cpu_grant;
    sel_addr    = pend_vld ? pend_addr  : bus.cpu_addr;
    sel_we      = pend_vld ? pend_we    : bus.cpu_we;
    sel_wdata   = pend_vld ? pend_wdata : bus.cpu_wdata;
  end

  // Access sequencer: IDLE -> ADDR -> DATA -> IDLE, or IDLE -> REFUSE -> IDLE for a refused host write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner_host <= 1'b0;
      a_q        <= IDLE_ADDR;
      write_q    <= 1'b0;
      din_q      <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_grant) begin
            state      <= S_ADDR;
            owner_host <= 1'b0;
            a_q        <= sel_addr;
            write_q    <= sel_we;
            din_q      <= sel_wdata;
          end else if (host_grant) begin
            owner_host <= 1'b1;
            if (host_refuse) begin
              state <= S_REFUSE;
            end else begin
              state   <= S_ADDR;
              a_q     <= bus.host_addr;
              write_q <= bus.host_we;
              din_q   <= bus.host_wdata;
            end
          end
        end
        S_ADDR: begin
          state   <= S_DATA;
          write_q <= 1'b0;
        end
        S_DATA: begin
          state <= S_IDLE;
          a_q   <= IDLE_ADDR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Completion: capture Dout for the owner on the DATA->IDLE edge and pulse its ack for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
      host_err_q   <= 1'b0;
    end else begin
      cpu_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
      host_err_q <= 1'b0;
      if (state == S_DATA) begin
        if (owner_host) begin
          host_ack_q   <= 1'b1;
          host_rdata_q <= bus.Dout;
        end else begin
          cpu_ack_q   <= 1'b1;
          cpu_rdata_q <= bus.Dout;
        end
      end else if (state == S_REFUSE) begin
        host_ack_q <= 1'b1;
        host_err_q <= 1'b1;
      end
    end
  end

  // CPU pending slot: holds one deferred strobe; a strobe that finds it occupied is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld   <= 1'b0;
      pend_addr  <= 8'h00;
      pend_we    <= 1'b0;
      pend_wdata <= 8'h00;
      overrun_q  <= 1'b0;
    end else begin
      if (cpu_to_slot && slot_free) begin
        pend_vld   <= 1'b1;
        pend_addr  <= bus.cpu_addr;
        pend_we    <= bus.cpu_we;
        pend_wdata <= bus.cpu_wdata;
      end else if (cpu_grant) begin
        pend_vld <= 1'b0;
      end
      if (cpu_to_slot && !slot_free) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Host starvation counter: counts ungranted requesting cycles, saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'h00;
    end else if (!bus.host_req || host_grant) begin
      wait_cnt <= 8'h00;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign bus.A           = a_q;
  assign bus.write       = write_q;
  assign bus.Din         = din_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_overrun = overrun_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_err    = host_err_q;

endmodule

// File: tb/tb_monitor_bus_arbiter.sv
// Directed bench for monitor_bus_arbiter with a registered-read window model.
// Latency: checks ack timing cycle by cycle.
// Backpressure: exercises pending slot, overrun and host starvation guard.
module tb_monitor_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  monitor_bus_arbiter_if bus();

  monitor_bus_arbiter #(
    .IDLE_ADDR      (8'h00),
    .MAX_WAIT       (8'd4),
    .ALLOW_RUN_WRITE(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // window model: 1-cycle registered read, write lands on the strobe edge
  logic [7:0] mem [256];
  always @(posedge clk) begin
    bus.Dout <= mem[bus.A];
    if (bus.write) mem[bus.A] <= bus.Din;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = 8'h00;
    bus.cpu_we     = 1'b0;
    bus.cpu_wdata  = 8'h00;
    bus.host_req   = 1'b0;
    bus.host_addr  = 8'h00;
    bus.host_we    = 1'b0;
    bus.host_wdata = 8'h00;
  endtask

  logic [7:0] exp_a [16];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'hE0] = 8'h11;
    mem[8'hE1] = 8'h5A;
    mem[8'hE2] = 8'h77;
    mem[8'hE3] = 8'h44;
    exp_a = '{8'h00, 8'hC0, 8'hC0, 8'h00, 8'hC3, 8'hC3, 8'h00, 8'hE2,
              8'hE2, 8'h00, 8'hC6, 8'hC6, 8'h00, 8'hC9, 8'hC9, 8'h00};
    rst_n = 1'b0;
    bus.stopped = 1'b0;
    drive_idle();
    tick();
    tick();

    // reset state
    chk_eq("rst_A", bus.A, 8'h00);
    chk_eq("rst_write", 8'(bus.write), 8'h00);
    chk_eq("rst_Din", bus.Din, 8'h00);
    chk_eq("rst_cpu_ack", 8'(bus.cpu_ack), 8'h00);
    chk_eq("rst_host_ack", 8'(bus.host_ack), 8'h00);
    chk_eq("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    chk_eq("rst_host_rdata", bus.host_rdata, 8'h00);
    chk_eq("rst_host_err", 8'(bus.host_err), 8'h00);
    chk_eq("rst_overrun", 8'(bus.cpu_overrun), 8'h00);
    rst_n = 1'b1;
    tick();

    // CPU read of E1
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'hE1; bus.cpu_we = 1'b0;
    tick();
    bus.cpu_req = 1'b0;
    chk_eq("rd_addr_A", bus.A, 8'hE1);
    chk_eq("rd_addr_write", 8'(bus.write), 8'h00);
    chk_eq("rd_addr_ack", 8'(bus.cpu_ack), 8'h00);
    tick();
    chk_eq("rd_data_A", bus.A, 8'hE1);
    chk_eq("rd_data_write", 8'(bus.write), 8'h00);
    chk_eq("rd_data_ack", 8'(bus.cpu_ack), 8'h00);
    tick();
    chk_eq("rd_ack", 8'(bus.cpu_ack), 8'h01);
    chk_eq("rd_rdata", bus.cpu_rdata, 8'h5A);
    chk_eq("rd_idle_A", bus.A, 8'h00);
    tick();
    chk_eq("rd_ack_pulse", 8'(bus.cpu_ack), 8'h00);

    // CPU write of 33 to E0
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'hE0; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h33;
    tick();
    drive_idle();
    chk_eq("wr_addr_write", 8'(bus.write), 8'h01);
    chk_eq("wr_addr_A", bus.A, 8'hE0);
    chk_eq("wr_addr_Din", bus.Din, 8'h33);
    tick();
    chk_eq("wr_data_write", 8'(bus.write), 8'h00);
    chk_eq("wr_data_A", bus.A, 8'hE0);
    tick();
    chk_eq("wr_ack", 8'(bus.cpu_ack), 8'h01);
    chk_eq("wr_rdata_prewrite", bus.cpu_rdata, 8'h11);
    chk_eq("wr_mem", mem[8'hE0], 8'h33);
    tick();

    // simultaneous CPU and host, wait counter at zero
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'hE1;
    bus.host_req = 1'b1; bus.host_addr = 8'hE2;
    tick();
    bus.cpu_req = 1'b0;
    chk_eq("sim_cpu_first_A", bus.A, 8'hE1);
    tick();
    tick();
    chk_eq("sim_cpu_ack", 8'(bus.cpu_ack), 8'h01);
    chk_eq("sim_host_not_yet", 8'(bus.host_ack), 8'h00);
    tick();
    chk_eq("sim_host_A", bus.A, 8'hE2);
    tick();
    tick();
    chk_eq("sim_host_ack", 8'(bus.host_ack), 8'h01);
    chk_eq("sim_host_rdata", bus.host_rdata, 8'h77);
    chk_eq("sim_host_err", 8'(bus.host_err), 8'h00);
    bus.host_req = 1'b0;
    tick();

    // host starvation guard with CPU strobing every third cycle
    bus.host_addr = 8'hE2;
    for (int k = 0; k < 16; k++) begin
      chk_eq($sformatf("starve_A_%0d", k), bus.A, exp_a[k]);
      chk_eq($sformatf("starve_cpu_ack_%0d", k), 8'(bus.cpu_ack),
             8'(k == 3 || k == 6 || k == 12 || k == 15));
      chk_eq($sformatf("starve_host_ack_%0d", k), 8'(bus.host_ack), 8'(k == 9));
      bus.host_req = (k < 9);
      bus.cpu_req  = ((k % 3) == 0) && (k <= 9);
      bus.cpu_addr = 8'(8'hC0 + k);
      tick();
    end
    drive_idle();
    chk_eq("starve_no_overrun", 8'(bus.cpu_overrun), 8'h00);
    tick();

    // three CPU strobes around one host access: two served in order, third dropped
    bus.host_req = 1'b1; bus.host_addr = 8'hE2;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'hC1;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    chk_eq("ovr_host_ack", 8'(bus.host_ack), 8'h01);
    bus.host_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'hC2;
    tick();
    chk_eq("ovr_first_A", bus.A, 8'hC1);
    chk_eq("ovr_clear_before", 8'(bus.cpu_overrun), 8'h00);
    bus.cpu_addr = 8'hC3;
    tick();
    bus.cpu_req = 1'b0;
    chk_eq("ovr_set", 8'(bus.cpu_overrun), 8'h01);
    tick();
    chk_eq("ovr_first_ack", 8'(bus.cpu_ack), 8'h01);
    chk_eq("ovr_first_rdata", bus.cpu_rdata, 8'h64);
    tick();
    chk_eq("ovr_second_A", bus.A, 8'hC2);
    tick();
    tick();
    chk_eq("ovr_second_ack", 8'(bus.cpu_ack), 8'h01);
    chk_eq("ovr_second_rdata", bus.cpu_rdata, 8'h67);
    tick();
    chk_eq("ovr_third_dropped_A", bus.A, 8'h00);
    chk_eq("ovr_sticky", 8'(bus.cpu_overrun), 8'h01);
    tick();

    // reset in the middle of an access with a pending strobe
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'hC4;
    tick();
    chk_eq("mid_A", bus.A, 8'hC4);
    bus.cpu_addr = 8'hC5;
    tick();
    bus.cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_A", bus.A, 8'h00);
    chk_eq("mid_rst_overrun", 8'(bus.cpu_overrun), 8'h00);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_eq($sformatf("mid_no_ack_%0d", k), 8'(bus.cpu_ack), 8'h00);
      chk_eq($sformatf("mid_idle_A_%0d", k), bus.A, 8'h00);
      tick();
    end

    // host read to give host_rdata a known non-zero value
    bus.host_req = 1'b1; bus.host_addr = 8'hE2; bus.host_we = 1'b0;
    tick();
    tick();
    tick();
    chk_eq("hrd_ack", 8'(bus.host_ack), 8'h01);
    chk_eq("hrd_rdata", bus.host_rdata, 8'h77);
    bus.host_req = 1'b0;
    tick();

    // host write while running: refused
    bus.stopped = 1'b0;
    bus.host_req = 1'b1; bus.host_addr = 8'hE3; bus.host_we = 1'b1; bus.host_wdata = 8'h99;
    tick();
    chk_eq("ref_write", 8'(bus.write), 8'h00);
    chk_eq("ref_A", bus.A, 8'h00);
    chk_eq("ref_ack_early", 8'(bus.host_ack), 8'h00);
    tick();
    chk_eq("ref_ack", 8'(bus.host_ack), 8'h01);
    chk_eq("ref_err", 8'(bus.host_err), 8'h01);
    chk_eq("ref_rdata_kept", bus.host_rdata, 8'h77);
    chk_eq("ref_mem", mem[8'hE3], 8'h44);
    bus.host_req = 1'b0;
    tick();
    chk_eq("ref_write_after", 8'(bus.write), 8'h00);

    // host write while stopped: performed
    bus.stopped = 1'b1;
    bus.host_req = 1'b1;
    tick();
    chk_eq("hwr_write", 8'(bus.write), 8'h01);
    chk_eq("hwr_A", bus.A, 8'hE3);
    chk_eq("hwr_Din", bus.Din, 8'h99);
    tick();
    chk_eq("hwr_write_low", 8'(bus.write), 8'h00);
    tick();
    chk_eq("hwr_ack", 8'(bus.host_ack), 8'h01);
    chk_eq("hwr_err", 8'(bus.host_err), 8'h00);
    chk_eq("hwr_rdata_prewrite", bus.host_rdata, 8'h44);
    chk_eq("hwr_mem", mem[8'hE3], 8'h99);
    drive_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/monitor_bus_arbiter.md
Name: monitor_bus_arbiter

Overview:
- Shares the monitor register/ROM window between two requesters:
  - the 6502-side bus logic (CPU port);
  - a host debug link, e.g. a serial bridge (host port).
- Drives the window's address/write/write-data lines and captures its read data.
- The window has 1-cycle registered read latency, and writes take effect on the clock edge where write=1.
- Every access uses a fixed 3-cycle sequence. CPU has priority, with a starvation guard for the host.

Parameters:
- IDLE_ADDR, 8'h00: address driven when idle. Must be outside the register range so idle cycles have no side effects.
- MAX_WAIT, 8'd16: number of host-waiting cycles after which the host wins the next arbitration. Range 1..255.
- ALLOW_RUN_WRITE, 1'b0: when 1, host writes are permitted while the CPU is not stopped.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  1-cycle request strobe
- cpu_addr  in  8  CPU access address, sampled with cpu_req
- cpu_we  in  1  CPU write enable, sampled with cpu_req
- cpu_wdata  in  8  CPU write data, sampled with cpu_req
- cpu_ack  out  1  1-cycle completion pulse for the CPU port
- cpu_rdata  out  8  CPU read data, valid with cpu_ack
- cpu_overrun  out  1  sticky: a CPU request was dropped
- host_req  in  1  level request, held until host_ack
- host_addr  in  8  host access address, sampled at grant
- host_we  in  1  host write enable, sampled at grant
- host_wdata  in  8  host write data, sampled at grant
- host_ack  out  1  1-cycle completion pulse for the host port
- host_rdata  out  8  host read data, valid with host_ack
- host_err  out  1  valid with host_ack: write refused
- stopped  in  1  CPU halted indication from the monitor control block
- A  out  8  address to the monitor window
- write  out  1  write strobe to the monitor window
- Din  out  8  write data to the monitor window
- Dout  in  8  read data from the monitor window

Behaviour:
- Reset values: A=IDLE_ADDR; write=0; Din=0; all acks, rdata, host_err, cpu_overrun = 0; counters/flags 0; state IDLE.
- Reset mid-access aborts the access with no ack; the pending CPU request is discarded.
- States:
  - IDLE: A=IDLE_ADDR, write=0.
  - ADDR: A=latched addr, write=latched we, Din=latched wdata.
  - DATA: A held, write=0.
  - DATA always returns to IDLE.
  - On the DATA->IDLE edge, rdata of the owner is loaded from Dout and its ack is pulsed high for the following cycle.
  - Latency: request sampled in IDLE at edge N → ack high in cycle N+3. Back-to-back throughput is 1 access per 3 cycles.
- Write-strobe timing: write is high for exactly one cycle (ADDR), so a register write lands on the ADDR->DATA edge. Read data for a write access returns the pre-write value.
- CPU pending slot:
  - A cpu_req seen outside IDLE, or losing arbitration, is latched into a single pending slot (addr/we/wdata).
  - A cpu_req arriving while the slot is full is dropped and sets cpu_overrun (sticky until reset).
- Arbitration in IDLE:
  - Candidates are (cpu_req | cpu_pend) and host_req.
  - CPU wins unless host_req=1 and wait_cnt>=MAX_WAIT, in which case the host wins and any same-cycle cpu_req goes to pending.
  - Pending CPU is served before a new simultaneous cpu_req. The new one becomes pending.
- wait_cnt (8-bit, saturating):
  - increments each cycle host_req=1 and the host is not granted;
  - clears on host grant or when host_req=0.
- Host write refusal:
  - Applies when host_we=1, stopped=0 and ALLOW_RUN_WRITE=0.
  - The host is granted but no bus cycle occurs; returns to IDLE after one cycle.
  - host_ack pulses with host_err=1 on the next cycle; host_rdata is unchanged.
  - host_err=0 on all other acks.
- A host read is always permitted.
- host_req must stay high until host_ack. The arbiter samples host_* at grant only.
- A host_req still high in the cycle of host_ack counts as a new request.

Test Plan:
- CPU read 8'hE1 with Dout=8'h5A in DATA → A=E1 for 2 cycles, write never high, cpu_ack 3 cycles after req, cpu_rdata=5A.
- CPU write 8'hE0 data 8'h33 → write=1 only in ADDR with A=E0, Din=33; cpu_ack at +3.
- host_req and cpu_req in the same IDLE cycle, wait_cnt=0 → CPU served first; host granted next IDLE; host_ack at +6.
- Host waiting with cpu_req every 3rd cycle, MAX_WAIT=4 → host granted once wait_cnt≥4; the coincident cpu_req is pending and served next; no overrun.
- Three cpu_req within one host access → first two served in order, third dropped, cpu_overrun=1 until rst_n low.
- Host write with stopped=0, ALLOW_RUN_WRITE=0 → no write pulse, host_ack with host_err=1 two cycles after grant. With stopped=1 the write proceeds, host_err=0.
